// File: rtl/deadtime_pkg.sv
// Shared definitions for the three-phase dead-time gate-drive stage.
package deadtime_pkg;

  localparam int unsigned DT_WIDTH_DEF = 8;

  // Safe maximum dead time loaded at reset (all ones).
  localparam logic [DT_WIDTH_DEF-1:0] DT_RESET = '1;

  // Per-phase FSM state encoding.
  typedef logic [1:0] phaseState_t;
  localparam phaseState_t S_DEAD = 2'd0;
  localparam phaseState_t S_HS   = 2'd1;
  localparam phaseState_t S_LS   = 2'd2;

endpackage

// File: rtl/deadtime_phase.sv
// One half-bridge leg: dead-time FSM, counter, target bit and registered gate pair.
module deadtime_phase
  import deadtime_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm,
  input  logic                force_off,
  input  logic [DT_WIDTH-1:0] dead_time,
  output logic                gate_h,
  output logic                gate_l
);

  phaseState_t         state, stateNext;
  logic [DT_WIDTH-1:0] cnt, cntNext;
  logic                target, targetNext;

  // Next-state logic; a toggle during the dead interval restarts the count.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    targetNext = target;
    if (force_off) begin
      stateNext  = S_DEAD;
      cntNext    = '0;
      targetNext = pwm;
    end else begin
      case (state)
        S_HS: begin
          if (!pwm) begin
            stateNext  = S_DEAD;
            targetNext = 1'b0;
            cntNext    = '0;
          end
        end
        S_LS: begin
          if (pwm) begin
            stateNext  = S_DEAD;
            targetNext = 1'b1;
            cntNext    = '0;
          end
        end
        default: begin
          if (pwm != target) begin
            targetNext = pwm;
            cntNext    = '0;
          end else if (cnt == dead_time - DT_WIDTH'(1)) begin
            stateNext = target ? S_HS : S_LS;
            cntNext   = '0;
          end else begin
            cntNext = cnt + DT_WIDTH'(1);
          end
        end
      endcase
    end
  end

  // State registers; gates are decoded from the next state so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_DEAD;
      cnt    <= '0;
      target <= 1'b0;
      gate_h <= 1'b0;
      gate_l <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      target <= targetNext;
      gate_h <= (stateNext == S_HS);
      gate_l <= (stateNext == S_LS);
    end
  end

endmodule

// File: rtl/pwm_deadtime.sv
// Three-phase complementary gate drive with programmable dead time and fault shutdown.
// Optional feature macro: PWM_DEADTIME_FAULT_LATCH_EN (latching fault, cleared by iFault_clr).
module pwm_deadtime
  import deadtime_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iEn,
  input  logic [DT_WIDTH-1:0] iDead_time,
  input  logic                iPWM_u,
  input  logic                iPWM_v,
  input  logic                iPWM_w,
  input  logic                iFault_n,
  input  logic                iFault_clr,
  output logic                oGate_uh,
  output logic                oGate_ul,
  output logic                oGate_vh,
  output logic                oGate_vl,
  output logic                oGate_wh,
  output logic                oGate_wl,
  output logic                oFault
);

  logic [DT_WIDTH-1:0] dtCap;
  logic [DT_WIDTH-1:0] deadEff;
  logic [1:0]          faultSync;
  logic                faultActive;
  logic                forceOff;

  // Dead time tracks the input while disabled and freezes while running.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)   dtCap <= '1;
    else if (!iEn) dtCap <= iDead_time;
  end

  assign deadEff = (dtCap == '0) ? DT_WIDTH'(1) : dtCap;

  // Two-flop synchroniser for the asynchronous fault input.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) faultSync <= 2'b11;
    else         faultSync <= {faultSync[0], iFault_n};
  end

  assign faultActive = ~faultSync[1];

`ifdef PWM_DEADTIME_FAULT_LATCH_EN
  // Fault latches until cleared while the synchronised fault is inactive.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)          oFault <= 1'b0;
    else if (faultActive) oFault <= 1'b1;
    else if (iFault_clr)  oFault <= 1'b0;
  end

  assign forceOff = ~iEn | faultActive | oFault;
`else
  // Fault flag follows the synchronised fault.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) oFault <= 1'b0;
    else         oFault <= faultActive;
  end

  assign forceOff = ~iEn | faultActive;

  logic unusedFaultClr;
  assign unusedFaultClr = iFault_clr;
`endif

  deadtime_phase #(.DT_WIDTH(DT_WIDTH)) uPhaseU (
    .clk       (iClk),
    .rst_n     (iRst_n),
    .pwm       (iPWM_u),
    .force_off (forceOff),
    .dead_time (deadEff),
    .gate_h    (oGate_uh),
    .gate_l    (oGate_ul)
  );

  deadtime_phase #(.DT_WIDTH(DT_WIDTH)) uPhaseV (
    .clk       (iClk),
    .rst_n     (iRst_n),
    .pwm       (iPWM_v),
    .force_off (forceOff),
    .dead_time (deadEff),
    .gate_h    (oGate_vh),
    .gate_l    (oGate_vl)
  );

  deadtime_phase #(.DT_WIDTH(DT_WIDTH)) uPhaseW (
    .clk       (iClk),
    .rst_n     (iRst_n),
    .pwm       (iPWM_w),
    .force_off (forceOff),
    .dead_time (deadEff),
    .gate_h    (oGate_wh),
    .gate_l    (oGate_wl)
  );

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: cycle table plus hand-written corner sequences.
// Gate vectors are packed {uh, ul, vh, vl, wh, wl}.
module tb_pwm_deadtime;
  import deadtime_pkg::*;

  localparam int unsigned DW = 8;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iEn;
  logic [DW-1:0] iDead_time;
  logic          iPWM_u, iPWM_v, iPWM_w;
  logic          iFault_n;
  logic          iFault_clr;
  logic          oGate_uh, oGate_ul, oGate_vh, oGate_vl, oGate_wh, oGate_wl;
  logic          oFault;

  int nChecks = 0;
  int nFails  = 0;

  pwm_deadtime #(.DT_WIDTH(DW)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iEn        (iEn),
    .iDead_time (iDead_time),
    .iPWM_u     (iPWM_u),
    .iPWM_v     (iPWM_v),
    .iPWM_w     (iPWM_w),
    .iFault_n   (iFault_n),
    .iFault_clr (iFault_clr),
    .oGate_uh   (oGate_uh),
    .oGate_ul   (oGate_ul),
    .oGate_vh   (oGate_vh),
    .oGate_vl   (oGate_vl),
    .oGate_wh   (oGate_wh),
    .oGate_wl   (oGate_wl),
    .oFault     (oFault)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic          en;
    logic [DW-1:0] dt;
    logic          pu, pv, pw;
    logic [5:0]    gates;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic en, input logic [DW-1:0] dt,
                              input logic pu, input logic pv, input logic pw,
                              input logic [5:0] gates);
    vec_t v;
    v.en = en; v.dt = dt; v.pu = pu; v.pv = pv; v.pw = pw; v.gates = gates;
    return v;
  endfunction

  function automatic logic [5:0] gatesNow();
    return {oGate_uh, oGate_ul, oGate_vh, oGate_vl, oGate_wh, oGate_wl};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; legs must never shoot through.
  task automatic tick();
    @(posedge iClk);
    #1;
    check("no_overlap", {29'd0, oGate_uh & oGate_ul, oGate_vh & oGate_vl, oGate_wh & oGate_wl}, 32'd0);
  endtask

  int  k;
  logic vhSeen;

  initial begin
    // Dead time 5 from release (last en=0 edge = -1): gates at edge 4.
    // pu rises at 6 -> uh at 11; pw glitch 12..14, ends at 15 -> wl at 20;
    // pu falls at 16 -> ul at 21; dt changed to 10 while enabled is ignored.
    vecs[0]  = mk(1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[1]  = mk(1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[2]  = mk(1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[3]  = mk(1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 6'b000000);
    vecs[4]  = mk(1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 6'b010101);
    vecs[5]  = mk(1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 6'b010101);
    vecs[6]  = mk(1'b1, 8'd5,  1'b1, 1'b0, 1'b0, 6'b000101);
    vecs[7]  = mk(1'b1, 8'd5,  1'b1, 1'b0, 1'b0, 6'b000101);
    vecs[8]  = mk(1'b1, 8'd5,  1'b1, 1'b0, 1'b0, 6'b000101);
    vecs[9]  = mk(1'b1, 8'd5,  1'b1, 1'b0, 1'b0, 6'b000101);
    vecs[10] = mk(1'b1, 8'd5,  1'b1, 1'b0, 1'b0, 6'b000101);
    vecs[11] = mk(1'b1, 8'd5,  1'b1, 1'b0, 1'b0, 6'b100101);
    vecs[12] = mk(1'b1, 8'd10, 1'b1, 1'b0, 1'b1, 6'b100100);
    vecs[13] = mk(1'b1, 8'd10, 1'b1, 1'b0, 1'b1, 6'b100100);
    vecs[14] = mk(1'b1, 8'd10, 1'b1, 1'b0, 1'b1, 6'b100100);
    vecs[15] = mk(1'b1, 8'd10, 1'b1, 1'b0, 1'b0, 6'b100100);
    vecs[16] = mk(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 6'b000100);
    vecs[17] = mk(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 6'b000100);
    vecs[18] = mk(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 6'b000100);
    vecs[19] = mk(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 6'b000100);
    vecs[20] = mk(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 6'b000101);
    vecs[21] = mk(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 6'b010101);
    vecs[22] = mk(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 6'b010101);

    iRst_n = 1'b0; iEn = 1'b0; iDead_time = 8'd5;
    iPWM_u = 1'b0; iPWM_v = 1'b0; iPWM_w = 1'b0;
    iFault_n = 1'b1; iFault_clr = 1'b0;
    #2;
    check("reset_gates", 32'(gatesNow()), 32'd0);
    check("reset_fault", 32'(oFault), 32'd0);
    repeat (2) @(posedge iClk);
    #1 iRst_n = 1'b1;
    repeat (3) tick();
    check("disabled_gates", 32'(gatesNow()), 32'd0);

    for (int i = 0; i < 23; i++) begin
      iEn = vecs[i].en; iDead_time = vecs[i].dt;
      iPWM_u = vecs[i].pu; iPWM_v = vecs[i].pv; iPWM_w = vecs[i].pw;
      tick();
      check($sformatf("vec%0d", i), 32'(gatesNow()), 32'(vecs[i].gates));
    end

    // Zero dead time clamps to one cycle.
    iEn = 1'b0; iDead_time = 8'd0;
    repeat (2) tick();
    check("clamp_disabled", 32'(gatesNow()), 32'd0);
    iEn = 1'b1;
    tick();
    check("clamp_release", 32'(gatesNow()), 32'h15);
    iPWM_u = 1'b1;
    tick();
    check("clamp_rise_dead", 32'(gatesNow()), 32'h05);
    tick();
    check("clamp_rise_uh", 32'(gatesNow()), 32'h25);
    iPWM_u = 1'b0;
    tick();
    check("clamp_fall_dead", 32'(gatesNow()), 32'h05);
    tick();
    check("clamp_fall_ul", 32'(gatesNow()), 32'h15);

    // Dead time 8, 3-cycle glitch on v: vh never asserts.
    iEn = 1'b0; iDead_time = 8'd8;
    repeat (2) tick();
    iEn = 1'b1;
    repeat (8) tick();
    check("dt8_release", 32'(gatesNow()), 32'h15);
    iPWM_v = 1'b1;
    vhSeen = 1'b0;
    repeat (3) begin
      tick();
      if (oGate_vh) vhSeen = 1'b1;
      check("glitch_v_dead", {30'd0, oGate_vh, oGate_vl}, 32'd0);
    end
    iPWM_v = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
      if (oGate_vh) vhSeen = 1'b1;
    end while (!oGate_vl && k < 30);
    // Glitch-end edge plus 8 dead cycles.
    check("glitch_vl_return", 32'(k), 32'd9);
    check("glitch_vh_never", 32'(vhSeen), 32'd0);

    // Recapture dead time 10.
    iEn = 1'b0; iDead_time = 8'd10;
    repeat (2) tick();
    iEn = 1'b1;
    repeat (9) tick();
    check("dt10_before", 32'(gatesNow()), 32'd0);
    tick();
    check("dt10_release", 32'(gatesNow()), 32'h15);
    iPWM_u = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!oGate_uh && k < 30);
    check("dt10_uh_edges", 32'(k), 32'd11);

    // Fault pulse with dead time 5.
    iEn = 1'b0; iDead_time = 8'd5;
    repeat (2) tick();
    iEn = 1'b1;
    repeat (6) tick();
    check("pre_fault", 32'(gatesNow()), 32'h25);
    iFault_n = 1'b0;
    tick();
    check("fault_sync1", 32'(gatesNow()), 32'h25);
    iFault_n = 1'b1;
    tick();
    check("fault_sync2", 32'(gatesNow()), 32'h25);
    check("fault_flag_early", 32'(oFault), 32'd0);
    tick();
    check("fault_gates_off", 32'(gatesNow()), 32'd0);
    check("fault_flag", 32'(oFault), 32'd1);
`ifdef PWM_DEADTIME_FAULT_LATCH_EN
    repeat (5) tick();
    check("latch_hold_gates", 32'(gatesNow()), 32'd0);
    check("latch_hold_flag", 32'(oFault), 32'd1);
    iFault_n = 1'b0;
    repeat (2) tick();
    iFault_clr = 1'b1;
    tick();
    iFault_clr = 1'b0;
    check("latch_clr_ignored", 32'(oFault), 32'd1);
    iFault_n = 1'b1;
    repeat (3) tick();
    iFault_clr = 1'b1;
    tick();
    iFault_clr = 1'b0;
    check("latch_cleared", 32'(oFault), 32'd0);
    check("latch_clr_gates", 32'(gatesNow()), 32'd0);
    repeat (4) tick();
    check("latch_dead", 32'(gatesNow()), 32'd0);
    tick();
    check("latch_resume", 32'(gatesNow()), 32'h25);
`else
    tick();
    check("fault_flag_clear", 32'(oFault), 32'd0);
    check("fault_dead0", 32'(gatesNow()), 32'd0);
    repeat (3) tick();
    check("fault_dead", 32'(gatesNow()), 32'd0);
    tick();
    check("fault_resume", 32'(gatesNow()), 32'h25);
`endif

    // Reset in the middle of a dead interval.
    iPWM_u = 1'b0;
    repeat (2) tick();
    iRst_n = 1'b0;
    #1;
    check("reset_async_gates", 32'(gatesNow()), 32'd0);
    check("reset_async_fault", 32'(oFault), 32'd0);
    #3 iRst_n = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (gatesNow() == 6'd0 && k < 300);
    check("reset_dt_edges", 32'(k), 32'(DT_RESET));
    check("reset_first_gates", 32'(gatesNow()), 32'h15);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
